// File: rtl/rgu_pkg.sv
// Shared definitions for the reset generation unit: sequencer states,
// rst_status bit positions and default timer width.
package rgu_pkg;

    typedef enum logic [2:0] {
        POR_WAIT    = 3'd0,
        ASSERT_ALL  = 3'd1,
        STAGE0      = 3'd2,
        STAGE1      = 3'd3,
        ASSERT_MAIN = 3'd4,
        RUN         = 3'd5
    } rgu_seq_state_e;

    localparam int RST_STS_POR  = 0;
    localparam int RST_STS_SYS  = 1;
    localparam int RST_STS_SB   = 2;
    localparam int RST_STS_WDT0 = 3;   // wdt_req[3:0] occupy [6:3]
    localparam int RST_STS_RSVD = 7;

    localparam int RGU_TMR_W = 16;

endpackage

// File: rtl/rgu_sync_filt.sv
// Synchronizes one active-low async reset source and optionally requires it to
// stay low for FILT_CYCLES synchronized cycles before raising req_o.
module rgu_sync_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic async_n_i,
    output logic req_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   low;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= async_n_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign low = ~sync_q[SYNC_STAGES-1];

    generate
        if (FILT_CYCLES == 0) begin : g_nofilt
            assign req_o = low;
        end else begin : g_filt
            localparam int CW = $clog2(FILT_CYCLES + 1);
            localparam logic [CW-1:0] FMAX = CW'(FILT_CYCLES);
            logic [CW-1:0] cnt_q, cnt_d;

            // cnt_q counts completed low cycles; req rises in the cycle after
            // FILT_CYCLES of them and drops combinationally on the first high.
            always_comb begin
                cnt_d = cnt_q;
                if (!low)             cnt_d = '0;
                else if (cnt_q != FMAX) cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) cnt_q <= '0;
                else          cnt_q <= cnt_d;
            end

            assign req_o = low && (cnt_q == FMAX);
        end
    endgenerate

endmodule

// File: rtl/rgu_rst_seq.sv
// Reset sequencer: conditions the reset sources, records the sticky cause and
// releases the sideband and main domains in two timed stages.
module rgu_rst_seq
    import rgu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int TMR_W       = RGU_TMR_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             sys_reset_n,
    input  logic             sb_wdt_rst_n,
    input  logic [3:0]       wdt_rst_n,
    input  logic [TMR_W-1:0] timer0_val,
    input  logic [TMR_W-1:0] timer1_val,
    input  logic             status_clr,
    output logic             stage0_done,
    output logic             stage1_done,
    output logic [7:0]       rst_status,
    output logic             seq_busy
);

    localparam logic [6:0] STS_RST = 7'(1) << RST_STS_POR;

    logic       sys_req, sb_req, any_wdt;
    logic [3:0] wdt_req;

    rgu_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sys_sync (
        .PCLK(PCLK), .PRESETn(PRESETn), .async_n_i(sys_reset_n), .req_o(sys_req)
    );

    rgu_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(0)) u_sb_sync (
        .PCLK(PCLK), .PRESETn(PRESETn), .async_n_i(sb_wdt_rst_n), .req_o(sb_req)
    );

    generate
        for (genvar g = 0; g < 4; g++) begin : g_wdt
            rgu_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(0)) u_wdt_sync (
                .PCLK(PCLK), .PRESETn(PRESETn), .async_n_i(wdt_rst_n[g]), .req_o(wdt_req[g])
            );
        end
    endgenerate

    assign any_wdt = |wdt_req;

    // Sticky cause register; a set in the same cycle as a clear wins.
    logic [6:0] sts_q, sts_d, sts_set;

    always_comb begin
        sts_set                       = '0;
        sts_set[RST_STS_SYS]          = sys_req;
        sts_set[RST_STS_SB]           = sb_req;
        sts_set[RST_STS_WDT0 +: 4]    = wdt_req;
        sts_d = (status_clr ? 7'd0 : sts_q) | sts_set;
    end

    rgu_seq_state_e   state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d, t0_ld, t1_ld;
    logic             s0_q, s0_d, s1_q, s1_d, busy_q;

    assign t0_ld = (timer0_val == '0) ? TMR_W'(1) : timer0_val;
    assign t1_ld = (timer1_val == '0) ? TMR_W'(1) : timer1_val;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        if (sys_req || sb_req) begin
            state_d = ASSERT_ALL;
            s0_d    = 1'b0;
            s1_d    = 1'b0;
        end else begin
            case (state_q)
                POR_WAIT, ASSERT_ALL: begin
                    if (state_q == ASSERT_ALL || !any_wdt) begin
                        state_d = STAGE0;
                        cnt_d   = t0_ld;
                    end
                end
                STAGE0: begin
                    if (cnt_q == TMR_W'(1)) begin
                        state_d = STAGE1;
                        cnt_d   = t1_ld;
                        s0_d    = 1'b1;
                    end else if (cnt_q > TMR_W'(1)) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                STAGE1: begin
                    if (any_wdt) begin
                        state_d = ASSERT_MAIN;
                        s1_d    = 1'b0;
                    end else if (cnt_q == TMR_W'(1)) begin
                        state_d = RUN;
                        s1_d    = 1'b1;
                    end else if (cnt_q > TMR_W'(1)) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ASSERT_MAIN: begin
                    s0_d = 1'b1;
                    s1_d = 1'b0;
                    if (!any_wdt) begin
                        state_d = STAGE1;
                        cnt_d   = t1_ld;
                    end
                end
                RUN: begin
                    if (any_wdt) begin
                        state_d = ASSERT_MAIN;
                        s1_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = POR_WAIT;
                    s0_d    = 1'b0;
                    s1_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= POR_WAIT;
            cnt_q   <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            busy_q  <= 1'b1;
            sts_q   <= STS_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            busy_q  <= (state_d != RUN);
            sts_q   <= sts_d;
        end
    end

    assign stage0_done = s0_q;
    assign stage1_done = s1_q;
    assign seq_busy    = busy_q;
    assign rst_status  = {1'b0, sts_q};

endmodule

// File: tb/tb_rgu_rst_seq.sv
// Directed bench for rgu_rst_seq: POR, watchdog, glitch filter, priority,
// zero timers with status clear, and asynchronous reset mid-count.
module tb_rgu_rst_seq;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        sys_reset_n, sb_wdt_rst_n;
    logic [3:0]  wdt_rst_n;
    logic [15:0] timer0_val, timer1_val;
    logic        status_clr;
    logic        stage0_done, stage1_done, seq_busy;
    logic [7:0]  rst_status;

    int n_cmp = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    rgu_rst_seq dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .sys_reset_n (sys_reset_n),
        .sb_wdt_rst_n(sb_wdt_rst_n),
        .wdt_rst_n   (wdt_rst_n),
        .timer0_val  (timer0_val),
        .timer1_val  (timer1_val),
        .status_clr  (status_clr),
        .stage0_done (stage0_done),
        .stage1_done (stage1_done),
        .rst_status  (rst_status),
        .seq_busy    (seq_busy)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic s0, input logic s1,
                           input logic busy, input logic [7:0] sts);
        chk({tag, ".s0"},   {7'd0, stage0_done}, {7'd0, s0});
        chk({tag, ".s1"},   {7'd0, stage1_done}, {7'd0, s1});
        chk({tag, ".busy"}, {7'd0, seq_busy},    {7'd0, busy});
        chk({tag, ".sts"},  rst_status,          sts);
    endtask

    initial begin
        PRESETn      = 1'b0;
        sys_reset_n  = 1'b1;
        sb_wdt_rst_n = 1'b1;
        wdt_rst_n    = 4'hF;
        timer0_val   = 16'd10;
        timer1_val   = 16'd20;
        status_clr   = 1'b0;
        cyc(2);
        chk_all("reset", 1'b0, 1'b0, 1'b1, 8'h01);

        // POR: STAGE0 entered on first edge, s0 after 10, s1 20 later
        PRESETn = 1'b1;
        cyc(10);  chk_all("por_s0_pre", 1'b0, 1'b0, 1'b1, 8'h01);
        cyc(1);   chk_all("por_s0",     1'b1, 1'b0, 1'b1, 8'h01);
        cyc(19);  chk_all("por_s1_pre", 1'b1, 1'b0, 1'b1, 8'h01);
        cyc(1);   chk_all("por_run",    1'b1, 1'b1, 1'b0, 8'h01);

        // Main watchdog 2 one-cycle pulse: drop after 3 edges, back 20 after exit
        wdt_rst_n = 4'b1011;
        cyc(1);   wdt_rst_n = 4'hF;
        cyc(1);   chk_all("wdt_pre",    1'b1, 1'b1, 1'b0, 8'h01);
        cyc(1);   chk_all("wdt_drop",   1'b1, 1'b0, 1'b1, 8'h21);
        cyc(20);  chk_all("wdt_s1_pre", 1'b1, 1'b0, 1'b1, 8'h21);
        cyc(1);   chk_all("wdt_run",    1'b1, 1'b1, 1'b0, 8'h21);

        // sys_reset_n glitch of 3 cycles is filtered out
        sys_reset_n = 1'b0;
        cyc(3);   sys_reset_n = 1'b1;
        cyc(8);   chk_all("glitch3", 1'b1, 1'b1, 1'b0, 8'h21);

        // 6 cycles low: outputs drop 7 edges after the fall, then resequence
        sys_reset_n = 1'b0;
        cyc(6);   chk_all("sys6_pre", 1'b1, 1'b1, 1'b0, 8'h21);
        sys_reset_n = 1'b1;
        cyc(1);   chk_all("sys6_drop",   1'b0, 1'b0, 1'b1, 8'h23);
        cyc(11);  chk_all("sys6_s0_pre", 1'b0, 1'b0, 1'b1, 8'h23);
        cyc(1);   chk_all("sys6_s0",     1'b1, 1'b0, 1'b1, 8'h23);
        cyc(19);  chk_all("sys6_s1_pre", 1'b1, 1'b0, 1'b1, 8'h23);
        cyc(1);   chk_all("sys6_run",    1'b1, 1'b1, 1'b0, 8'h23);

        // Sideband and wdt0 together: sideband wins, both causes recorded
        sb_wdt_rst_n = 1'b0;
        wdt_rst_n    = 4'b1110;
        cyc(2);   chk_all("prio_pre", 1'b1, 1'b1, 1'b0, 8'h23);
        cyc(1);   chk_all("prio",     1'b0, 1'b0, 1'b1, 8'h2F);

        // Zero timers: each stage lasts one cycle
        timer0_val   = 16'd0;
        timer1_val   = 16'd0;
        sb_wdt_rst_n = 1'b1;
        wdt_rst_n    = 4'hF;
        cyc(3);   chk_all("zt_s0_pre", 1'b0, 1'b0, 1'b1, 8'h2F);
        cyc(1);   chk_all("zt_s0",     1'b1, 1'b0, 1'b1, 8'h2F);
        cyc(1);   chk_all("zt_run",    1'b1, 1'b1, 1'b0, 8'h2F);

        // status_clr in the cycle wdt_req[1] is high: set beats clear
        wdt_rst_n = 4'b1101;
        cyc(1);   wdt_rst_n = 4'hF;
        cyc(1);   status_clr = 1'b1;
        cyc(1);   status_clr = 1'b0;
        chk_all("clr_set", 1'b1, 1'b0, 1'b1, 8'h10);
        cyc(1);   chk("clr_hold.sts", rst_status, 8'h10);
        cyc(1);   chk_all("clr_run", 1'b1, 1'b1, 1'b0, 8'h10);

        // Sideband pulse, then PRESETn while STAGE1 cnt is 7
        timer0_val   = 16'd10;
        timer1_val   = 16'd20;
        sb_wdt_rst_n = 1'b0;
        cyc(1);   sb_wdt_rst_n = 1'b1;
        cyc(26);  chk_all("mid_pre", 1'b1, 1'b0, 1'b1, 8'h14);
        #2 PRESETn = 1'b0;
        #1 chk_all("mid_async", 1'b0, 1'b0, 1'b1, 8'h01);
        cyc(2);   PRESETn = 1'b1;
        cyc(10);  chk_all("re_s0_pre", 1'b0, 1'b0, 1'b1, 8'h01);
        cyc(1);   chk_all("re_s0",     1'b1, 1'b0, 1'b1, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
